writeback_queue: RTL and testbench

Write-back initiator for the MIPS register file: collects results from the ALU and load paths, buffers them in a small in-order queue, and drains one write per cycle into the register file's single write port (`write_data`, `write_register`, `RegWrite`). Because a queued value is not yet in the register file, the block also forwards the newest pending value for the two register-file read addresses. It sits between the execute/memory stages and the register file.

---
 rtl/mips_pkg.sv | 14 +
 rtl/wb_fwd_match.sv | 35 +++
 rtl/writeback_queue.sv | 101 ++++++++++
 tb/tb_writeback_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS write-back path.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  regnum;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Newest-first search of the pending write-back entries for one read address.
module wb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0]       entries_i,
  input  logic [$clog2(DEPTH)-1:0]    head_i,
  input  logic [$clog2(DEPTH):0]      count_i,
  input  logic [REG_W-1:0]            raddr_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && (raddr_i != REG_ZERO) &&
          (entries_i[idx].regnum == raddr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue: merges load/ALU results, drains one register-file
// write per cycle, and forwards the newest pending value for two read ports.
module writeback_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_W-1:0]         mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_W-1:0]         alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  output logic [DATA_W-1:0]        write_data,
  output logic [REG_W-1:0]         write_register,
  output logic                     RegWrite,
  input  logic [REG_W-1:0]         read_register1,
  input  logic [REG_W-1:0]         read_register2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] entries_q;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic             pop;
  logic [CNT_W-1:0] free;
  logic             mem_store, alu_store;
  logic [PTR_W-1:0] alu_slot;

  // The head pops every cycle it is valid, so its slot is reusable this edge.
  assign pop  = (count_q != '0);
  assign free = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

  assign mem_ready = !rst && (free >= CNT_W'(1));
  assign alu_ready = !rst && (free >= (mem_valid ? CNT_W'(2) : CNT_W'(1)));

  // Writes to $0 are accepted but dropped without taking a slot.
  assign mem_store = mem_valid && mem_ready && (mem_reg != REG_ZERO);
  assign alu_store = alu_valid && alu_ready && (alu_reg != REG_ZERO);
  assign alu_slot  = tail_q + PTR_W'(mem_store);

  always_comb begin
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(mem_store) + PTR_W'(alu_store);
    count_d = count_q - CNT_W'(pop) + CNT_W'(mem_store) + CNT_W'(alu_store);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_store) entries_q[tail_q] <= '{regnum: mem_reg, data: mem_data};
    if (alu_store) entries_q[alu_slot] <= '{regnum: alu_reg, data: alu_data};
  end

  assign RegWrite       = pop;
  assign write_register = pop ? entries_q[head_q].regnum : '0;
  assign write_data     = pop ? entries_q[head_q].data : '0;
  assign count          = count_q;

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .raddr_i   (read_register1),
    .hit_o     (fwd_hit1),
    .data_o    (fwd_data1)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .raddr_i   (read_register2),
    .hit_o     (fwd_hit2),
    .data_o    (fwd_data2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_reg, alu_reg;
  logic [31:0] mem_data, alu_data;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        RegWrite;
  logic [4:0]  read_register1, read_register2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [CW-1:0] count;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_reg        (mem_reg),
    .mem_data       (mem_data),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_reg        (alu_reg),
    .alu_data       (alu_data),
    .write_data     (write_data),
    .write_register (write_register),
    .RegWrite       (RegWrite),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .fwd_hit1       (fwd_hit1),
    .fwd_hit2       (fwd_hit2),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_free();
    return DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
  endfunction

  task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].r == a) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    logic        h;
    logic [31:0] d;
    int          fr;
    fr = model_free();
    chk("count", 32'(count), 32'(mq.size()));
    chk("RegWrite", 32'(RegWrite), 32'(mq.size() > 0));
    chk("write_register", 32'(write_register), (mq.size() > 0) ? 32'(mq[0].r) : 32'd0);
    chk("write_data", write_data, (mq.size() > 0) ? mq[0].d : 32'd0);
    chk("mem_ready", 32'(mem_ready), 32'(!rst && fr >= 1));
    chk("alu_ready", 32'(alu_ready), 32'(!rst && fr >= (mem_valid ? 2 : 1)));
    model_fwd(read_register1, h, d);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
    chk("fwd_data1", fwd_data1, d);
    model_fwd(read_register2, h, d);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
    chk("fwd_data2", fwd_data2, d);
  endtask

  // Called right after the edge; inputs are still those seen by the edge.
  task automatic model_update(input int fr_pre, input int sz_pre);
    bit ma, aa;
    if (rst) begin
      mq.delete();
    end else begin
      ma = mem_valid && (fr_pre >= 1);
      aa = alu_valid && (fr_pre >= (mem_valid ? 2 : 1));
      if (sz_pre > 0) void'(mq.pop_front());
      if (ma && mem_reg != 5'd0) mq.push_back('{r: mem_reg, d: mem_data});
      if (aa && alu_reg != 5'd0) mq.push_back('{r: alu_reg, d: alu_data});
    end
  endtask

  task automatic drive(input logic r, input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst = r; mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    read_register1 = r1; read_register2 = r2;
    #1;
  endtask

  task automatic idle(input logic r, input logic [4:0] r1, input logic [4:0] r2);
    drive(r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  task automatic tick();
    int fr, sz;
    model_check();
    fr = model_free();
    sz = mq.size();
    @(posedge clk);
    model_update(fr, sz);
    @(negedge clk);
  endtask

  logic [4:0]  wr_reg [$];
  logic [31:0] wr_dat [$];
  int          rn;

  initial begin
    @(negedge clk);

    // Reset, then a single ALU write.
    idle(1'b1, 5'd0, 5'd0);
    tick();
    tick();
    idle(1'b0, 5'd0, 5'd0);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    chk("single_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle(1'b0, 5'd0, 5'd0);
    chk("single_RegWrite", 32'(RegWrite), 32'd1);
    chk("single_wreg", 32'(write_register), 32'd5);
    chk("single_wdata", write_data, 32'hDEADBEEF);
    tick();
    idle(1'b0, 5'd0, 5'd0);
    chk("single_RegWrite_after", 32'(RegWrite), 32'd0);
    tick();

    // Simultaneous accept: mem older, alu younger.
    drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, 5'd0);
    chk("both_mem_ready", 32'(mem_ready), 32'd1);
    chk("both_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle(1'b0, 5'd3, 5'd0);
    chk("both_first_wdata", write_data, 32'h11);
    chk("both_fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("both_fwd_data1", fwd_data1, 32'h22);
    chk("both_count", 32'(count), 32'd2);
    tick();
    idle(1'b0, 5'd3, 5'd0);
    chk("both_second_wdata", write_data, 32'h22);
    chk("both_fwd_head", fwd_data1, 32'h22);
    tick();
    idle(1'b0, 5'd0, 5'd0);
    chk("both_drained", 32'(RegWrite), 32'd0);
    tick();

    // Both producers every cycle: queue fills and alu stalls.
    rn = 1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 5'(rn), 32'h1000 + 32'(rn), 1'b1, 5'(rn + 1), 32'h2000 + 32'(rn + 1),
            5'(rn), 5'(rn + 1));
      if (i >= 4) begin
        chk("full_count", 32'(count), 32'd4);
        chk("full_alu_stall", 32'(alu_ready), 32'd0);
        chk("full_mem_ready", 32'(mem_ready), 32'd1);
      end
      tick();
      rn = (rn >= 29) ? 1 : rn + 2;
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b0, 5'(i + 1), 5'(i + 2));
      tick();
    end
    chk("full_drained", 32'(count), 32'd0);

    // Register $0 is accepted and dropped.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("zero_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle(1'b0, 5'd0, 5'd0);
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_RegWrite", 32'(RegWrite), 32'd0);
    chk("zero_fwd_hit2", 32'(fwd_hit2), 32'd0);
    tick();

    // Reset with entries pending.
    drive(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd0, 5'd0);
    tick();
    idle(1'b1, 5'd9, 5'd10);
    chk("midrst_count_before", 32'(count), 32'd3);
    chk("midrst_ready_low", 32'(mem_ready), 32'd0);
    tick();
    idle(1'b0, 5'd9, 5'd10);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_RegWrite", 32'(RegWrite), 32'd0);
    chk("midrst_fwd_hit1", 32'(fwd_hit1), 32'd0);
    chk("midrst_fwd_hit2", 32'(fwd_hit2), 32'd0);
    tick();

    // Wrap-around: ten sequential writes through the pointers.
    for (int i = 0; i < 13; i++) begin
      if (i < 10)
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h100 + 32'(i + 1), 5'd0, 5'd0);
      else
        idle(1'b0, 5'd0, 5'd0);
      if (RegWrite) begin
        wr_reg.push_back(write_register);
        wr_dat.push_back(write_data);
      end
      tick();
    end
    chk("wrap_nwrites", 32'(wr_reg.size()), 32'd10);
    for (int k = 0; k < wr_reg.size() && k < 10; k++) begin
      chk("wrap_reg", 32'(wr_reg[k]), 32'(k + 1));
      chk("wrap_data", wr_dat[k], 32'h100 + 32'(k + 1));
    end

    // Randomized traffic with small register range for frequent matches.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
